sma_in: RTL and testbench

//  Avalon-MM slave parallel input port: the receive-side counterpart of the single-bit SMA output PIO.

---
 rtl/sma_in.sv | 155 +++++++++++++++
 tb/tb_sma_in.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sma_in.sv
// ---------------------------------------------------------------------------
// sma_in
//
// Avalon-MM slave parallel input port. This is the receive-side partner of
// the SMA output PIO. It brings an asynchronous external bus into the clk
// domain, latches the selected edges in a sticky capture register, and raises
// a maskable level interrupt for the Nios II.
//
// Parameters
//   WIDTH        number of input bits (1..32)
//   SYNC_STAGES  synchroniser flops per bit (2..4)
//   EDGE_TYPE    0 = rising, 1 = falling, 2 = any edge captured
//
// Ports
//   clk        system clock; all logic is on posedge
//   reset_n    asynchronous active-low reset
//   address    register select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    external asynchronous input bus
//   readdata   read data, combinational from address
//   irq        level interrupt, active high, registered
//
// Bus handshake: there are no wait states. A write is accepted on the clk
// edge where chipselect is high and write_n is low. readdata is a pure decode
// of address with zero latency. Reads have no side effects.
// ---------------------------------------------------------------------------
module sma_in #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Synchroniser chain. Stage 0 is the metastability-catching flop, and the
    // last stage is the value the rest of the design uses.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic             irq_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // prev clears to 0 on reset. As a result, a bit that is already high
    // after reset is reported as a rising edge once the chain refills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync;
        end
    end

    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    assign wr_en = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
        end else if (wr_en && (address == ADDR_IRQMASK)) begin
            irq_mask_q <= writedata;
        end
    end

    // Write-1-to-clear. An edge that arrives on the same cycle as a clear of
    // the same bit wins, so that event is never lost.
    always_comb begin
        clear_bits = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clear_bits = writedata;
        end
    end

    assign edge_capture_d = edge_det | (edge_capture_q & ~clear_bits);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_q <= '0;
        end else begin
            edge_capture_q <= edge_capture_d;
        end
    end

    // irq is registered from the current capture and mask. It therefore
    // follows a capture set, a clear, or a mask write by one cycle. The mask
    // gates only irq: capture continues while a bit is masked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(edge_capture_q & irq_mask_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = sync;
            ADDR_IRQMASK: readdata = irq_mask_q;
            ADDR_EDGECAP: readdata = edge_capture_q;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sma_in.sv
// ---------------------------------------------------------------------------
// tb_sma_in
//
// Directed bench for sma_in. Three instances share every input and differ
// only in EDGE_TYPE: rising, falling and any edge. All instances use WIDTH=4
// and SYNC_STAGES=2. Every expected value below is worked out by hand from
// the register behaviour.
// ---------------------------------------------------------------------------
module tb_sma_in;

    logic       clk;
    logic       reset_n;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [3:0] writedata;
    logic [3:0] in_port;
    logic [3:0] rd0, rd1, rd2;
    logic       irq0, irq1, irq2;

    int total;
    int bad;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sma_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    sma_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    sma_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 4'h0;
        in_port    = 4'h0;

        // 1: held in reset while in_port toggles
        in_port = 4'hF; tick();
        in_port = 4'h5; tick();
        in_port = 4'hA; tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk($sformatf("rst_hold_rise_a%0d", a), rd0, 4'h0);
            chk($sformatf("rst_hold_any_a%0d", a), rd2, 4'h0);
        end
        chk("rst_hold_irq_rise", {3'b0, irq0}, 4'h0);
        chk("rst_hold_irq_fall", {3'b0, irq1}, 4'h0);
        chk("rst_hold_irq_any",  {3'b0, irq2}, 4'h0);
        in_port = 4'h0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk($sformatf("rst_rel_a%0d", a), rd0, 4'h0);
        end

        // 2: synchroniser latency and ignored DATA write
        in_port = 4'hA;
        rd(2'd0); chk("sync_lat0", rd0, 4'h0);
        tick();
        rd(2'd0); chk("sync_lat1", rd0, 4'h0);
        tick();
        rd(2'd0); chk("sync_lat2", rd0, 4'hA);
        bus_write(2'd0, 4'h5);
        rd(2'd0); chk("data_wr_ignored", rd0, 4'hA);
        rd(2'd3);
        chk("cap_after_A_rise", rd0, 4'hA);
        chk("cap_after_A_fall", rd1, 4'h0);
        chk("cap_after_A_any",  rd2, 4'hA);
        bus_write(2'd3, 4'hF);
        rd(2'd3);
        chk("cap_clear_all_rise", rd0, 4'h0);
        chk("cap_clear_all_any",  rd2, 4'h0);

        // 3: rising capture on bit0, mask=1
        bus_write(2'd2, 4'h1);
        rd(2'd2); chk("mask_rd", rd0, 4'h1);
        in_port = 4'hB;
        tick(); tick(); tick();
        rd(2'd3); chk("rise_cap_bit0", rd0, 4'h1);
        chk("rise_irq_not_yet", {3'b0, irq0}, 4'h0);
        tick();
        chk("rise_irq_set", {3'b0, irq0}, 4'h1);
        in_port = 4'hA;
        tick(); tick(); tick(); tick();
        rd(2'd3);
        chk("fall_no_change_rise", rd0, 4'h1);
        chk("fall_cap_fall",       rd1, 4'h1);
        chk("fall_cap_any",        rd2, 4'h1);
        chk("fall_irq_rise", {3'b0, irq0}, 4'h1);
        chk("fall_irq_fall", {3'b0, irq1}, 4'h1);

        // 4: RW1C partial clear and irq drop timing
        in_port = 4'h0;
        tick(); tick(); tick(); tick();
        bus_write(2'd3, 4'hF);
        tick();
        in_port = 4'hF;
        tick(); tick(); tick();
        rd(2'd3); chk("rw1c_cap_F", rd0, 4'hF);
        bus_write(2'd2, 4'h5);
        tick();
        chk("rw1c_irq_before", {3'b0, irq0}, 4'h1);
        bus_write(2'd3, 4'h5);
        rd(2'd3); chk("rw1c_cap_A", rd0, 4'hA);
        chk("rw1c_irq_still", {3'b0, irq0}, 4'h1);
        tick();
        chk("rw1c_irq_drop", {3'b0, irq0}, 4'h0);

        // 5: edge on bit1 coincides with a write-1 clear of bit1
        bus_write(2'd2, 4'h2);
        tick();
        chk("simul_irq_pre", {3'b0, irq0}, 4'h1);
        in_port = 4'hD;
        tick(); tick(); tick(); tick();
        rd(2'd3); chk("simul_fall_ignored", rd0, 4'hA);
        in_port = 4'hF;
        tick(); tick();
        bus_write(2'd3, 4'h2);
        rd(2'd3); chk("simul_edge_wins", rd0, 4'hA);
        chk("simul_irq_held0", {3'b0, irq0}, 4'h1);
        tick();
        chk("simul_irq_held1", {3'b0, irq0}, 4'h1);
        bus_write(2'd3, 4'h2);
        rd(2'd3); chk("plain_clear_bit1", rd0, 4'h8);
        tick();
        chk("plain_clear_irq", {3'b0, irq0}, 4'h0);

        // 6: masked capture, then unmask
        bus_write(2'd3, 4'hF);
        bus_write(2'd2, 4'h0);
        tick();
        chk("masked_irq_idle", {3'b0, irq0}, 4'h0);
        in_port = 4'hB;
        tick(); tick(); tick(); tick();
        rd(2'd3);
        chk("masked_fall_rise", rd0, 4'h0);
        chk("masked_fall_fall", rd1, 4'h4);
        chk("masked_fall_any",  rd2, 4'h4);
        chk("masked_irq_any", {3'b0, irq2}, 4'h0);
        in_port = 4'hF;
        tick(); tick(); tick(); tick();
        rd(2'd3);
        chk("masked_rise_rise", rd0, 4'h4);
        chk("masked_rise_any",  rd2, 4'h4);
        chk("masked_irq_rise", {3'b0, irq0}, 4'h0);
        bus_write(2'd2, 4'h4);
        chk("unmask_irq_lag", {3'b0, irq0}, 4'h0);
        tick();
        chk("unmask_irq_rise", {3'b0, irq0}, 4'h1);
        chk("unmask_irq_any",  {3'b0, irq2}, 4'h1);

        // mid-operation reset, then a high input reads as rising
        reset_n = 1'b0;
        #1;
        chk("midrst_irq", {3'b0, irq0}, 4'h0);
        rd(2'd2); chk("midrst_mask", rd0, 4'h0);
        rd(2'd3); chk("midrst_cap",  rd0, 4'h0);
        rd(2'd0); chk("midrst_data", rd0, 4'h0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        rd(2'd3);
        chk("postrst_cap_rise", rd0, 4'hF);
        chk("postrst_cap_any",  rd2, 4'hF);
        chk("postrst_cap_fall", rd1, 4'h0);
        rd(2'd0); chk("postrst_data", rd0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
